// File: rtl/mem_pkg.sv
// Shared types and sizes for the core memory responder.
// Requester index covers the read ports plus the rw port.
package mem_pkg;
  localparam int MEM_AW     = 8;
  localparam int MEM_DW     = 16;
  localparam int MEM_DEPTH  = 256;
  localparam int MEM_RPORTS = 2;
  localparam int REQ_N      = MEM_RPORTS + 1;
  localparam int REQ_IW     = $clog2(REQ_N);

  typedef logic [MEM_AW-1:0] addr_t;
  typedef logic [MEM_DW-1:0] data_t;
  typedef logic [REQ_IW-1:0] req_idx_t;
endpackage

// File: rtl/mem_intf.sv
// Request/response bundles between core and core_mem.
// core drives the master side, core_mem the slave side.
interface mem_rport;
  import mem_pkg::*;
  logic  val;
  addr_t addr;
  logic  rdy;
  data_t rdata;
  modport master (output val, addr, input rdy, rdata);
  modport slave  (input val, addr, output rdy, rdata);
endinterface

interface mem_rwport;
  import mem_pkg::*;
  logic  val;
  logic  wen;
  addr_t addr;
  data_t wdata;
  logic  rdy;
  data_t rdata;
  modport master (output val, wen, addr, wdata, input rdy, rdata);
  modport slave  (input val, wen, addr, wdata, output rdy, rdata);
endinterface

// File: rtl/core_mem_rr_arb.sv
// Round-robin arbiter: one-hot grant plus index.
// Pointer moves past the winner; holds when idle.
module core_mem_rr_arb #(
  parameter int N = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          vld
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] jj;
  int            j;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!vld && req[jj]) begin
        vld     = 1'b1;
        idx     = jj;
        gnt[jj] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (vld) begin
      ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/core_mem.sv
// Memory responder: arbitrated reads into one sync RAM,
// zero-wait stores, one-entry bypass for read-during-write.
module core_mem
  import mem_pkg::*;
#(
  parameter int    N_RPORTS  = MEM_RPORTS,
  parameter string INIT_FILE = ""
) (
  input logic      clk_i,
  input logic      arst_i,
  mem_rport.slave  mem_r_intf [N_RPORTS],
  mem_rwport.slave mem_rw_intf
);
  localparam int NR = N_RPORTS + 1;
  localparam int IW = $clog2(NR);

  logic [NR-1:0] val;
  logic [NR-1:0] gnt;
  logic [NR-1:0] rdy;
  addr_t         addr [NR];
  logic [IW-1:0] gidx;
  logic          gvld;
  logic          st;
  addr_t         raddr;
  data_t         ram [MEM_DEPTH];
  data_t         ram_q;
  data_t         rsp;
  data_t         byp_data;
  logic          byp_hit;
  logic          inf;
  logic [IW-1:0] inf_idx;
  addr_t         inf_addr;
  data_t         hold [NR];

  for (genvar i = 0; i < N_RPORTS; i++) begin : g_rp
    assign val[i]  = mem_r_intf[i].val;
    assign addr[i] = mem_r_intf[i].addr;
    assign mem_r_intf[i].rdy   = rdy[i];
    assign mem_r_intf[i].rdata = rdy[i] ? rsp : hold[i];
  end

  // The rw port only competes for the read port while loading.
  assign st             = mem_rw_intf.val & mem_rw_intf.wen;
  assign val[N_RPORTS]  = mem_rw_intf.val & ~mem_rw_intf.wen;
  assign addr[N_RPORTS] = mem_rw_intf.addr;
  assign mem_rw_intf.rdy   = st | rdy[N_RPORTS];
  assign mem_rw_intf.rdata = rdy[N_RPORTS] ? rsp : hold[N_RPORTS];

  for (genvar i = 0; i < NR; i++) begin : g_rdy
    assign rdy[i] = inf && (inf_idx == IW'(i))
                    && val[i] && (addr[i] == inf_addr);
  end

  core_mem_rr_arb #(.N(NR)) u_arb (
    .clk (clk_i),
    .rst (arst_i),
    .req (val),
    .gnt (gnt),
    .idx (gidx),
    .vld (gvld)
  );

  always_comb begin
    raddr = '0;
    for (int i = 0; i < NR; i++) begin
      if (gnt[i]) raddr = addr[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (st) ram[mem_rw_intf.addr] <= mem_rw_intf.wdata;
    ram_q <= ram[raddr];
  end

  // RAM returns old data on a same-edge write; bypass covers it.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      inf      <= 1'b0;
      inf_idx  <= '0;
      inf_addr <= '0;
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      inf      <= gvld;
      inf_idx  <= gidx;
      inf_addr <= raddr;
      byp_hit  <= gvld && st && (mem_rw_intf.addr == raddr);
      byp_data <= mem_rw_intf.wdata;
    end
  end

  assign rsp = byp_hit ? byp_data : ram_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      for (int i = 0; i < NR; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (rdy[i]) hold[i] <= rsp;
      end
    end
  end
endmodule
